// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen_pkg: shared frame geometry defaults and helpers for the window generator
package conv_window_gen_pkg;
  localparam int DEF_QUAN_BITS = 8;
  localparam int DEF_IMG_WIDTH = 32;
  localparam int DEF_IMG_HIGH  = 32;

  function automatic int pad_dim(input int n);
    return n + 2;
  endfunction

  function automatic int last_pos(input int pad, input bit stride2);
    return (stride2 && (pad % 2 == 0)) ? pad - 2 : pad - 1;
  endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one padded-row store, combinational read, write on accepted beat
module conv_line_buffer #(
  parameter int DW = 24,
  parameter int DEPTH = 34,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          s_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] mem [DEPTH];
  assign o_rdata = mem[i_addr];
  // Row storage is deliberately unreset; stale rows never reach an emitted window
  always_ff @(posedge s_clk)
    if (i_we) mem[i_addr] <= i_wdata;
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: 3x3 window former over a padded pixel stream; CONV_WINDOW_STRIDE2_EN selects stride 2
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int QUAN_BITS = DEF_QUAN_BITS,
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int IMG_HIGH  = DEF_IMG_HIGH
) (
  input  logic                   s_clk,
  input  logic                   s_rst,
  output logic                   o_ready4data,
  input  logic [3*QUAN_BITS-1:0] i_data,
  input  logic                   i_data_valid,
  output logic [27*QUAN_BITS-1:0] o_window,
  output logic                   o_window_valid,
  input  logic                   i_pe_ready,
  output logic                   o_frame_done
);
  localparam int PIX   = 3 * QUAN_BITS;
  localparam int PAD_W = pad_dim(IMG_WIDTH);
  localparam int PAD_H = pad_dim(IMG_HIGH);
  localparam int CW    = $clog2(PAD_W);
  localparam int RW    = $clog2(PAD_H);
`ifdef CONV_WINDOW_STRIDE2_EN
  localparam bit STRIDE2 = 1'b1;
`else
  localparam bit STRIDE2 = 1'b0;
`endif
  localparam int LAST_C = last_pos(PAD_W, STRIDE2);
  localparam int LAST_R = last_pos(PAD_H, STRIDE2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PIX-1:0] lb0_q, lb1_q;
  logic [8:0][PIX-1:0] win_q, win_d;
  logic accept, emit, col_end, row_end;

  assign o_ready4data = !o_window_valid | i_pe_ready;
  assign accept  = i_data_valid & o_ready4data;
  assign col_end = col == CW'(PAD_W - 1);
  assign row_end = row == RW'(PAD_H - 1);
  assign emit    = accept && row >= RW'(2) && col >= CW'(2) && (!STRIDE2 || (!row[0] && !col[0]));
  assign win_d   = {i_data, win_q[8:7], lb0_q, win_q[5:4], lb1_q, win_q[2:1]};

  conv_line_buffer #(.DW(PIX), .DEPTH(PAD_W)) u_lb0 (
    .s_clk(s_clk), .i_we(accept), .i_addr(col), .i_wdata(i_data), .o_rdata(lb0_q)
  );

  conv_line_buffer #(.DW(PIX), .DEPTH(PAD_W)) u_lb1 (
    .s_clk(s_clk), .i_we(accept), .i_addr(col), .i_wdata(lb0_q), .o_rdata(lb1_q)
  );

  // Raster position of the next beat
  always_ff @(posedge s_clk)
    if (s_rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= col_end ? '0 : col + 1'b1;
      row <= col_end ? (row_end ? '0 : row + 1'b1) : row;
    end

  // Sliding 3x3 array; new right column is {LB1, LB0, incoming pixel}
  always_ff @(posedge s_clk)
    if (accept) win_q <= win_d;

  // Output window register, held while the PE stalls
  always_ff @(posedge s_clk)
    if (s_rst) begin
      o_window       <= '0;
      o_window_valid <= 1'b0;
      o_frame_done   <= 1'b0;
    end else begin
      o_window_valid <= emit | (o_window_valid & ~i_pe_ready);
      o_frame_done   <= emit && row == RW'(LAST_R) && col == CW'(LAST_C);
      if (emit) o_window <= win_d;
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed table-driven bench for conv_window_gen on a 4x4 frame
module tb_conv_window_gen;
  localparam int QB = 8;
  localparam int PW = 6;
  localparam int WW = 27 * QB;
`ifdef CONV_WINDOW_STRIDE2_EN
  localparam bit S2 = 1'b1;
`else
  localparam bit S2 = 1'b0;
`endif

  typedef struct {int r; int c; logic [WW-1:0] win; logic done;} vec_t;
  typedef struct {logic [WW-1:0] win; logic done;} obs_t;

  logic s_clk = 1'b0, s_rst = 1'b1, i_data_valid = 1'b0, i_pe_ready = 1'b1;
  logic o_ready4data, o_window_valid, o_frame_done;
  logic [3*QB-1:0] i_data = '0;
  logic [WW-1:0] o_window;
  vec_t vt[$];
  obs_t q[$];
  int total = 0, bad = 0, pidx = 0, done_cnt = 0;

  always #5 s_clk = ~s_clk;

  conv_window_gen #(.QUAN_BITS(QB), .IMG_WIDTH(4), .IMG_HIGH(4)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .o_ready4data(o_ready4data), .i_data(i_data),
    .i_data_valid(i_data_valid), .o_window(o_window), .o_window_valid(o_window_valid),
    .i_pe_ready(i_pe_ready), .o_frame_done(o_frame_done)
  );

  always @(negedge s_clk)
    if (!s_rst) begin
      if (o_window_valid && i_pe_ready) q.push_back('{o_window, o_frame_done});
      if (o_frame_done) done_cnt++;
    end

  function automatic logic [WW-1:0] win_at(input int r, input int c);
    logic [WW-1:0] w;
    logic [7:0] v;
    w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++) begin
        v = 8'((r - 2 + rr) * PW + (c - 2 + cc));
        w[(rr*3+cc)*24 +: 24] = {v, v, v};
      end
    return w;
  endfunction

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge s_clk);
    #1;
  endtask

  task automatic send(input int n, input int gap);
    int i, guard;
    logic acc;
    i = 0;
    guard = 0;
    while (i < n && guard < 2000) begin
      i_data = {3{8'(pidx % 36)}};
      i_data_valid = $urandom_range(0, 99) >= gap;
      @(negedge s_clk);
      acc = i_data_valid && o_ready4data;
      tick;
      if (acc) begin
        i++;
        pidx++;
      end
      guard++;
    end
    i_data_valid = 1'b0;
    chk("send_beats", WW'(i), WW'(n));
  endtask

  task automatic do_reset;
    s_rst = 1'b1;
    i_data_valid = 1'b0;
    i_pe_ready = 1'b1;
    tick;
    tick;
    s_rst = 1'b0;
    pidx = 0;
    q.delete();
    done_cnt = 0;
  endtask

  task automatic check_frames(input int nf, input string tag);
    int n;
    n = nf * vt.size();
    repeat (4) tick;
    chk({tag, "_count"}, WW'(q.size()), WW'(n));
    chk({tag, "_done_cnt"}, WW'(done_cnt), WW'(nf));
    for (int i = 0; i < q.size() && i < n; i++) begin
      vec_t e;
      e = vt[i % vt.size()];
      chk($sformatf("%s_win%0d_r%0dc%0d", tag, i, e.r, e.c), q[i].win, e.win);
      chk($sformatf("%s_done%0d", tag, i), WW'(q[i].done), WW'(e.done));
    end
    if (q.size() > 0) begin
      chk({tag, "_first_k0"}, WW'(q[0].win[0 +: 24]), WW'({3{8'd0}}));
      chk({tag, "_first_k4"}, WW'(q[0].win[4*24 +: 24]), WW'({3{8'd7}}));
      chk({tag, "_first_k8"}, WW'(q[0].win[8*24 +: 24]), WW'({3{8'd14}}));
      chk({tag, "_last_k4"}, WW'(q[q.size()-1].win[4*24 +: 24]), WW'({3{S2 ? 8'd21 : 8'd28}}));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int r = 2; r < 6; r++)
      for (int c = 2; c < 6; c++)
        if (!S2 || (r % 2 == 0 && c % 2 == 0))
          vt.push_back('{r, c, win_at(r, c), (r == (S2 ? 4 : 5)) && (c == (S2 ? 4 : 5))});
    tick;
    tick;
    chk("rst_valid", WW'(o_window_valid), '0);
    chk("rst_window", o_window, '0);
    chk("rst_done", WW'(o_frame_done), '0);
    chk("rst_ready", WW'(o_ready4data), WW'(1));
    s_rst = 1'b0;

    send(36, 0);
    check_frames(1, "cont");

    do_reset;
    i_pe_ready = 1'b0;
    send(15, 0);
    i_data = {3{8'(pidx % 36)}};
    i_data_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge s_clk);
      chk($sformatf("stall_ready%0d", k), WW'(o_ready4data), '0);
      chk($sformatf("stall_valid%0d", k), WW'(o_window_valid), WW'(1));
      chk($sformatf("stall_win%0d", k), o_window, vt[0].win);
      tick;
    end
    chk("stall_no_accept", WW'(pidx), WW'(15));
    i_pe_ready = 1'b1;
    send(1, 0);
    @(negedge s_clk);
    chk("stall_next_valid", WW'(o_window_valid), WW'(!S2));
    tick;
    send(20, 0);
    check_frames(1, "stall");

    do_reset;
    send(36, 50);
    check_frames(1, "gaps");

    do_reset;
    send(72, 0);
    check_frames(2, "two");

    do_reset;
    send(17, 0);
    s_rst = 1'b1;
    tick;
    chk("midrst_valid", WW'(o_window_valid), '0);
    chk("midrst_window", o_window, '0);
    chk("midrst_done", WW'(o_frame_done), '0);
    chk("midrst_ready", WW'(o_ready4data), WW'(1));
    s_rst = 1'b0;
    pidx = 0;
    q.delete();
    done_cnt = 0;
    send(36, 0);
    check_frames(1, "midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
